// File: rtl/lsab_pkg.sv
// lsab_pkg: shared constants, FIFO id type and write-scheduler FSM encodings for lsab_cw.
package lsab_pkg;

    localparam int LSAB_NFIFO = 4;
    localparam int LSAB_DW    = 32;

    typedef logic [1:0] fifo_id_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

endpackage

// File: rtl/lsab_rr_pick.sv
// lsab_rr_pick: combinational round-robin winner search starting after rr_ptr.
// LSAB_WSCHED_PRIO_EN: FIFO 0 wins whenever eligible.
module lsab_rr_pick
    import lsab_pkg::*;
(
    input  logic [LSAB_NFIFO-1:0] elig,
    input  fifo_id_t              rr_ptr,
    output logic                  found,
    output fifo_id_t              win
);

    fifo_id_t idx;

    // Walk from the farthest candidate back to rr_ptr+1 so the nearest eligible one sticks.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = LSAB_NFIFO; i >= 1; i--) begin
            idx = rr_ptr + fifo_id_t'(i);
            if (elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
`ifdef LSAB_WSCHED_PRIO_EN
        if (elig[0]) begin
            found = 1'b1;
            win   = '0;
        end
`endif
    end

endmodule

// File: rtl/lsab_cw_wsched.sv
// lsab_cw_wsched: round-robin burst scheduler sharing the lsab_cw write port among four producers.
// LSAB_WSCHED_PRIO_EN: FIFO 0 gets strict priority; FIFOs 1..3 keep rotating among themselves.
module lsab_cw_wsched
    import lsab_pkg::*;
#(
    parameter int BURST_MAX = 8,
    parameter int CNT_W     = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [LSAB_NFIFO-1:0] SRC_VALID,
    output logic [LSAB_NFIFO-1:0] SRC_READY,
    input  logic [LSAB_DW-1:0]    SRC_DATA_0,
    input  logic [LSAB_DW-1:0]    SRC_DATA_1,
    input  logic [LSAB_DW-1:0]    SRC_DATA_2,
    input  logic [LSAB_DW-1:0]    SRC_DATA_3,
    input  logic [LSAB_NFIFO-1:0] BFULL,
    output logic                  WRITE,
    output fifo_id_t              WRITE_FIFO,
    output logic [LSAB_DW-1:0]    IN,
    output logic                  BUSY
);

    logic [1:0]         state_q, state_d;
    fifo_id_t           gnt_q, gnt_d;
    fifo_id_t           rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    fifo_id_t           write_fifo_q, write_fifo_d;
    logic [LSAB_DW-1:0] in_q, in_d;
    logic               busy_q, busy_d;

    logic [LSAB_NFIFO-1:0] elig;
    logic                  found;
    fifo_id_t              win;
    logic [LSAB_DW-1:0]    gnt_data;
    logic                  accept;
    logic                  last;

    assign elig = SRC_VALID & ~BFULL;

    lsab_rr_pick u_pick (
        .elig   (elig),
        .rr_ptr (rr_ptr_q),
        .found  (found),
        .win    (win)
    );

    assign gnt_data = (gnt_q == 2'd0) ? SRC_DATA_0 :
                      (gnt_q == 2'd1) ? SRC_DATA_1 :
                      (gnt_q == 2'd2) ? SRC_DATA_2 : SRC_DATA_3;

    // BFULL lags the filling write by a cycle; the one word accepted meanwhile rides the FIFO headroom.
    assign accept    = (state_q == ST_BURST) & elig[gnt_q];
    assign SRC_READY = accept ? (LSAB_NFIFO'(1) << gnt_q) : '0;
    assign last      = cnt_q == CNT_W'(BURST_MAX - 1);

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        write_d      = accept;
        write_fifo_d = accept ? gnt_q : write_fifo_q;
        in_d         = accept ? gnt_data : in_q;
        if (state_q == ST_IDLE) begin
            if (found) begin
                state_d = ST_BURST;
                gnt_d   = win;
`ifdef LSAB_WSCHED_PRIO_EN
                rr_ptr_d = (win == 2'd0) ? rr_ptr_q : win;
`else
                rr_ptr_d = win;
`endif
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        end else if (state_q == ST_BURST) begin
            cnt_d = accept ? cnt_q + 1'b1 : cnt_q;
            if (!accept || last) begin
                state_d = ST_GAP;
                busy_d  = 1'b0;
            end
        end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            rr_ptr_q     <= 2'd3;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            write_fifo_q <= '0;
            in_q         <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            write_fifo_q <= write_fifo_d;
            in_q         <= in_d;
            busy_q       <= busy_d;
        end
    end

    assign WRITE      = write_q;
    assign WRITE_FIFO = write_fifo_q;
    assign IN         = in_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_lsab_cw_wsched.sv
// tb_lsab_cw_wsched: scoreboarded random and directed bench for lsab_cw_wsched.
module tb_lsab_cw_wsched;
    import lsab_pkg::*;

    localparam int BM = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  SRC_VALID = '0;
    logic [3:0]  BFULL = '0;
    logic [3:0]  SRC_READY;
    logic [31:0] sd [4];
    logic        WRITE, BUSY;
    logic [1:0]  WRITE_FIFO;
    logic [31:0] IN;

    lsab_cw_wsched #(.BURST_MAX(BM), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .SRC_VALID(SRC_VALID), .SRC_READY(SRC_READY),
        .SRC_DATA_0(sd[0]), .SRC_DATA_1(sd[1]), .SRC_DATA_2(sd[2]), .SRC_DATA_3(sd[3]),
        .BFULL(BFULL), .WRITE(WRITE), .WRITE_FIFO(WRITE_FIFO), .IN(IN), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct { int fifo; logic [31:0] data; int cyc; } exp_t;
    exp_t        sb[$];
    int          bursts[$];
    int          lens[$];
    logic [31:0] words[$];
    int errors = 0, checks = 0, cyc = 0;
    bit mon_en = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference model: burst/gap bookkeeping with a modulo-4 round-robin search.
    bit          m_burst, m_gap;
    int          m_rr, m_gnt, m_cnt;
    logic [31:0] cur [4];
    int          seq [4];
    bit          rnd_data = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic void model_reset();
        m_burst = 0; m_gap = 0; m_rr = 3; m_gnt = 0; m_cnt = 0;
        sb.delete();
    endfunction

    task automatic step(input logic [3:0] v, input logic [3:0] bf);
        logic [3:0] er;
        int pick;
        int n;
        @(negedge CLK);
        SRC_VALID = v;
        BFULL = bf;
        for (int i = 0; i < 4; i++) sd[i] = cur[i];
        #1;
        er = '0;
        if (m_burst && v[m_gnt] && !bf[m_gnt]) er[m_gnt] = 1'b1;
        chk("src_ready", 64'(SRC_READY), 64'(er));
        chk("busy", 64'(BUSY), 64'(m_burst));
        if (m_burst) begin
            if (er != 0) begin
                sb.push_back('{m_gnt, cur[m_gnt], cyc + 1});
                seq[m_gnt]++;
                cur[m_gnt] = rnd_data ? $urandom : 32'h100 + 32'(seq[m_gnt]);
                m_cnt++;
            end
            if (er == 0 || m_cnt == BM) begin
                m_burst = 0;
                m_gap = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            pick = -1;
`ifdef LSAB_WSCHED_PRIO_EN
            if (v[0] && !bf[0]) pick = 0;
`endif
            for (int k = 1; k <= 4 && pick < 0; k++) begin
                n = (m_rr + k) % 4;
                if (v[n] && !bf[n]) pick = n;
            end
            if (pick >= 0) begin
                m_burst = 1;
                m_gnt = pick;
                m_cnt = 0;
`ifdef LSAB_WSCHED_PRIO_EN
                if (pick != 0) m_rr = pick;
`else
                m_rr = pick;
`endif
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #3;
        RST = 1'b0;
        #1;
        chk("rst_write", 64'(WRITE), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_ready", 64'(SRC_READY), 64'd0);
        chk("rst_fifo", 64'(WRITE_FIFO), 64'd0);
        chk("rst_in", 64'(IN), 64'd0);
        SRC_VALID = '0;
        BFULL = '0;
        model_reset();
        bursts.delete(); lens.delete(); words.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        mon_en = 1;
    endtask

    initial begin : monitor
        exp_t e;
        bit prev_w;
        int run;
        prev_w = 0;
        run = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (!mon_en || !RST) begin
                prev_w = 0;
                run = 0;
            end else begin
                if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_write: got none want fifo %0d data 0x%0h at cycle %0d", e.fifo, e.data, e.cyc);
                end
                if (WRITE) begin
                    if (!prev_w) bursts.push_back(int'(WRITE_FIFO));
                    run++;
                    words.push_back(IN);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got fifo %0d data 0x%0h want no write (cycle %0d)", WRITE_FIFO, IN, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("write_fifo", 64'(WRITE_FIFO), 64'(e.fifo));
                        chk("write_data", 64'(IN), 64'(e.data));
                        chk("write_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end else if (prev_w) begin
                    lens.push_back(run);
                    run = 0;
                end
                prev_w = WRITE;
            end
        end
    end

    initial begin
`ifdef LSAB_WSCHED_PRIO_EN
        int order [5] = '{0, 0, 0, 0, 0};
`else
        int order [5] = '{0, 1, 2, 3, 0};
`endif
        logic [3:0] v, b;
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0;
            cur[i] = 32'h100;
            sd[i] = '0;
        end
        model_reset();
        do_reset();
        // Single producer on FIFO 1, sequential payload.
        repeat (30) step(4'b0010, 4'b0000);
        chk("a_nwords", 64'(words.size() >= 16), 64'd1);
        for (int k = 0; k < 16 && k < words.size(); k++) chk("a_word", 64'(words[k]), 64'(32'h100 + k));
        chk("a_len0", 64'(lens.size() > 0 ? lens[0] : -1), 64'(BM));
        chk("a_len1", 64'(lens.size() > 1 ? lens[1] : -1), 64'(BM));
        // All producers valid: grant order and burst lengths.
        do_reset();
        repeat (50) step(4'b1111, 4'b0000);
        chk("b_nbursts", 64'(bursts.size() >= 5), 64'd1);
        for (int k = 0; k < 5 && k < bursts.size(); k++) chk("b_order", 64'(bursts[k]), 64'(order[k]));
        for (int k = 0; k < 4 && k < lens.size(); k++) chk("b_len", 64'(lens[k]), 64'(BM));
        // FIFO 2 fills after its 3rd word; the in-flight 4th is still written, then FIFO 3 follows.
        do_reset();
        repeat (5) step(4'b1100, 4'b0000);
        repeat (14) step(4'b1100, 4'b0100);
        chk("c_first", 64'(bursts.size() > 0 ? bursts[0] : -1), 64'd2);
        chk("c_next", 64'(bursts.size() > 1 ? bursts[1] : -1), 64'd3);
        chk("c_len", 64'(lens.size() > 0 ? lens[0] : -1), 64'd4);
        // Producer drops VALID after two words; the next burst is full length again.
        do_reset();
        repeat (3) step(4'b0001, 4'b0000);
        repeat (3) step(4'b0000, 4'b0000);
        repeat (12) step(4'b0001, 4'b0000);
        chk("d_short", 64'(lens.size() > 0 ? lens[0] : -1), 64'd2);
        chk("d_full", 64'(lens.size() > 1 ? lens[1] : -1), 64'(BM));
        // Reset mid-burst, then FIFO 0 must be served first.
        repeat (6) step(4'b1111, 4'b0000);
        chk("e_busy_before", 64'(BUSY), 64'd1);
        do_reset();
        repeat (4) step(4'b1111, 4'b0000);
        chk("e_first", 64'(bursts.size() > 0 ? bursts[0] : -1), 64'd0);
        // Randomized traffic against the reference model.
        rnd_data = 1;
        repeat (1500) begin
            for (int i = 0; i < 4; i++) begin
                v[i] = ($urandom_range(3) != 0);
                b[i] = ($urandom_range(6) == 0);
            end
            step(v, b);
        end
        repeat (4) step(4'b0000, 4'b0000);
        chk("drain", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
